fifo_wr_arbiter: RTL
====================

Name: fifo_wr_arbiter

Overview:
- Round-robin, packet-locked write arbiter that shares one synchronous FIFO write port among N requesters.
- Each requester presents a valid/ready stream with a last flag. The arbiter grants one requester and holds that grant until its packet's last beat is written, so packets never interleave in the FIFO.
- It drives the FIFO wen/data_in and obeys the FIFO's registered full flag.

Parameters:
- N, 4, number of requesters (2..16).
- W, 32, data width per requester and FIFO entry width.
- IDW, $clog2(N), grant-index width; fixed by N, not overridable.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  reset, asynchronous and active-high.
- req_valid  input  N  per-requester beat valid.
- req_data  input  N*W  requester i data occupies bits [i*W +: W].
- req_last  input  N  per-requester last-beat-of-packet flag.
- req_ready  output  N  per-requester beat accepted this cycle when valid&ready.
- fifo_full  input  1  FIFO full flag (registered in FIFO).
- fifo_wen  output  1  FIFO write enable.
- fifo_wdata  output  W  FIFO write data.
- busy  output  1  1 while in BURST state.
- grant_id  output  IDW  index of the currently locked requester.

Behaviour:
- States:
  - IDLE: no lock.
  - BURST: locked to grant_id.
- Reset (rst=1, asynchronous, any cycle including mid-packet):
  - State IDLE, grant_id=0, rr pointer=0.
  - busy=0, fifo_wen=0, req_ready=0.
  - A partially written packet stays in the FIFO; discarding it is the system's responsibility.
- Arbitration in IDLE:
  - If any req_valid is set, pick the first valid index found by searching upward from the rr pointer, wrapping N-1 to 0.
  - Register the winner into grant_id and enter BURST next cycle.
  - No beat transfers in IDLE. This gives a fixed 1-cycle arbitration bubble per packet.
  - If no valid, stay IDLE.
- BURST:
  - req_ready[grant_id] = !fifo_full. All other req_ready bits are 0. req_ready is combinational from state and fifo_full and does not depend on req_valid.
  - fifo_wen = req_valid[grant_id] & !fifo_full.
  - fifo_wdata = req_data slice of grant_id, muxed every cycle. Value is don't-care when fifo_wen=0.
  - On a transferred beat with req_last[grant_id]=1: go to IDLE and set rr pointer = grant_id+1, wrapping at N. grant_id holds its value in IDLE.
  - Granted requester deasserts valid mid-packet: the lock is held, no beat is written, and the arbiter waits indefinitely.
  - fifo_full=1: no write, lock held, state unchanged.
  - Single-beat packet (last on first beat): 1 write, then back to IDLE.
- Throughput:
  - Max one beat per cycle.
  - A packet of L beats occupies L+1 cycles minimum (bubble + L).
- Fairness:
  - Each requester waits at most N-1 other packets before it is granted.
  - Non-winning requesters keep valid asserted, see ready=0, and must hold data and last stable.
- busy = (state==BURST).
- req_last on a non-granted requester is ignored.

Test Plan:
- Reset, then N=4 with only req 2 valid, 3-beat packet data 0xA0,0xA1,0xA2 (last on 0xA2), fifo_full=0 → grant_id=2 at cycle 1, fifo_wen high cycles 2-4 with wdata A0,A1,A2, busy falls after cycle 4, rr pointer=3.
- All 4 requesters continuously valid with 1-beat packets from reset → grants in order 0,1,2,3,0; exactly one write every 2 cycles; req_ready only ever one-hot or zero.
- Req 1 granted with a 4-beat packet, fifo_full=1 for 3 cycles after beat 2 → fifo_wen=0 and req_ready[1]=0 during the stall, then beats 3,4 write in order, with no beat lost or duplicated.
- Req 0 granted, deasserts valid for 2 cycles mid-packet while req 3 stays valid → grant_id stays 0, no writes, req_ready[3]=0 throughout; packet resumes and completes before req 3 is granted.
- Assert rst during beat 2 of a 5-beat packet from req 3 → next cycle busy=0, fifo_wen=0, grant_id=0. After release with reqs 0 and 3 valid, req 0 is granted first (pointer reset to 0).
- Scoreboard randomized run with N=4, W=32, random valid/last/full over 10k cycles → FIFO stream equals per-requester packets concatenated without interleaving, and no requester waits more than 3 packets.

Source files
------------

// File: rtl/fifo_wr_arbiter_if.sv
// Requester streams plus FIFO write port shared by the arbiter.
// The master modport drives requests and the full flag; the slave modport is the arbiter.
interface fifo_wr_arbiter_if #(
  parameter int N = 4,
  parameter int W = 32
);
  localparam int IDW = $clog2(N);

  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_last;
  logic [N-1:0]   req_ready;
  logic           fifo_full;
  logic           fifo_wen;
  logic [W-1:0]   fifo_wdata;
  logic           busy;
  logic [IDW-1:0] grant_id;

  modport master (
    output req_valid, req_data, req_last, fifo_full,
    input  req_ready, fifo_wen, fifo_wdata, busy, grant_id
  );

  modport slave (
    input  req_valid, req_data, req_last, fifo_full,
    output req_ready, fifo_wen, fifo_wdata, busy, grant_id
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, packet-locked arbiter sharing one FIFO write port among N requesters.
//   state | meaning
//   IDLE  | no lock; pick next valid requester from the rr pointer
//   BURST | locked to grant_id until its last beat is written
module fifo_wr_arbiter #(
  parameter int N = 4,
  parameter int W = 32
) (
  input logic          clk,
  input logic          rst,
  fifo_wr_arbiter_if.slave bus
);
  localparam int IDW = $clog2(N);

  typedef enum logic {IDLE, BURST} state_t;

  state_t         state;
  logic [IDW-1:0] grant_q;
  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] pick_idx;
  logic           pick_valid;
  logic           sel_valid;
  logic           sel_last;
  logic           wen;

  // Scanning downward leaves the closest valid index at or above rr_ptr as the winner.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (bus.req_valid[(int'(rr_ptr) + k) % N]) begin
        pick_valid = 1'b1;
        pick_idx   = IDW'((int'(rr_ptr) + k) % N);
      end
    end
  end

  always_comb begin
    bus.req_ready = '0;
    if (state == BURST) bus.req_ready[grant_q] = !bus.fifo_full;
  end

  assign sel_valid      = bus.req_valid[grant_q];
  assign sel_last       = bus.req_last[grant_q];
  assign wen            = (state == BURST) && sel_valid && !bus.fifo_full;
  assign bus.fifo_wen   = wen;
  assign bus.fifo_wdata = bus.req_data[int'(grant_q) * W +: W];
  assign bus.busy       = (state == BURST);
  assign bus.grant_id   = grant_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      grant_q <= '0;
      rr_ptr  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_valid) begin
            grant_q <= pick_idx;
            state   <= BURST;
          end
        end
        BURST: begin
          if (wen && sel_last) begin
            state  <= IDLE;
            rr_ptr <= (grant_q == IDW'(N - 1)) ? '0 : grant_q + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
